// File: rtl/aq_biu_wtable_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : aq_biu_wtable_if
// Purpose  : Allocate/retire/query bundle of the BIU write-outstanding table
// Revision : 1.0 - initial release
// ============================================================================
interface aq_biu_wtable_if #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 2,
  parameter int PADDR = 40
);
  logic             wtable_create_vld;
  logic [PADDR-1:0] wtable_create_addr;
  logic             wtable_create_so;
  logic             wtable_create_burst;
  logic             wtable_create_rdy;
  logic [IDX_W-1:0] wtable_create_idx;
  logic             wtable_pop_vld;
  logic [IDX_W-1:0] wtable_pop_idx;
  logic [PADDR-1:0] araddr;
  logic [3:0]       arcache;
  logic [PADDR-1:0] awaddr;
  logic [3:0]       awcache;
  logic [1:0]       awlen;
  logic             ar_hit_wtable_addr;
  logic             ar_hit_wtable_so;
  logic             aw_hit_wtable_addr;
  logic             aw_hit_wtable_so;
  logic [DEPTH-1:0] wtable_vld;
  logic [IDX_W:0]   wtable_cnt;
  logic             wtable_full;
  logic             wtable_empty;
  logic             wtable_pop_err;

  modport slave (
    input  wtable_create_vld, wtable_create_addr, wtable_create_so,
           wtable_create_burst, wtable_pop_vld, wtable_pop_idx,
           araddr, arcache, awaddr, awcache, awlen,
    output wtable_create_rdy, wtable_create_idx,
           ar_hit_wtable_addr, ar_hit_wtable_so,
           aw_hit_wtable_addr, aw_hit_wtable_so,
           wtable_vld, wtable_cnt, wtable_full, wtable_empty, wtable_pop_err
  );

  modport master (
    output wtable_create_vld, wtable_create_addr, wtable_create_so,
           wtable_create_burst, wtable_pop_vld, wtable_pop_idx,
           araddr, arcache, awaddr, awcache, awlen,
    input  wtable_create_rdy, wtable_create_idx,
           ar_hit_wtable_addr, ar_hit_wtable_so,
           aw_hit_wtable_addr, aw_hit_wtable_so,
           wtable_vld, wtable_cnt, wtable_full, wtable_empty, wtable_pop_err
  );
endinterface
`default_nettype wire

// File: rtl/aq_biu_wtable.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : aq_biu_wtable
// Purpose  : DEPTH-entry write-outstanding table with address/SO hazard flags
// Revision : 1.0 - initial release
// ============================================================================
module aq_biu_wtable #(
  parameter int DEPTH   = 4,
  parameter int IDX_W   = 2,
  parameter int PADDR   = 40,
  parameter int CMP_HI  = 13,
  parameter int LINE_LO = 6,
  parameter int SUB_LO  = 4
) (
  input  wire logic      forever_cpuclk,
  input  wire logic      cpurst,
  aq_biu_wtable_if.slave bus
);

  localparam int               c_addr_w   = CMP_HI - SUB_LO + 1;
  localparam int               c_line_off = LINE_LO - SUB_LO;
  localparam logic [IDX_W:0]   c_depth    = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   c_one      = (IDX_W+1)'(1);

  logic [DEPTH-1:0]    r_vld;
  logic [DEPTH-1:0]    r_so;
  logic [DEPTH-1:0]    r_burst;
  logic [c_addr_w-1:0] r_addr [DEPTH];
  logic [IDX_W:0]      r_cnt;
  logic                r_pop_err;

  logic                w_full;
  logic                w_create_fire;
  logic                w_pop_hit;
  logic                w_pop_miss;
  logic [IDX_W-1:0]    w_free_idx;
  logic [DEPTH-1:0]    w_ar_hit;
  logic [DEPTH-1:0]    w_aw_hit;
  logic                w_so_pend;

  assign w_full        = (r_cnt == c_depth);
  assign w_create_fire = bus.wtable_create_vld & ~w_full;
  assign w_pop_hit     = bus.wtable_pop_vld &  r_vld[bus.wtable_pop_idx];
  assign w_pop_miss    = bus.wtable_pop_vld & ~r_vld[bus.wtable_pop_idx];

  // Descending scan so the lowest free index is the one left standing; 0 when full.
  always_comb begin
    w_free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!r_vld[i]) begin
        w_free_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_vld   <= '0;
      r_so    <= '0;
      r_burst <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
      end
    end else begin
      if (w_create_fire) begin
        r_vld[w_free_idx]   <= 1'b1;
        r_so[w_free_idx]    <= bus.wtable_create_so;
        r_burst[w_free_idx] <= bus.wtable_create_burst;
        r_addr[w_free_idx]  <= bus.wtable_create_addr[CMP_HI:SUB_LO];
      end
      // Pop only touches a valid entry, so it never collides with the create slot.
      if (w_pop_hit) begin
        r_vld[bus.wtable_pop_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_cnt     <= '0;
      r_pop_err <= 1'b0;
    end else begin
      r_pop_err <= w_pop_miss;
      case ({w_create_fire, w_pop_hit})
        2'b10:   r_cnt <= r_cnt + c_one;
        2'b01:   r_cnt <= r_cnt - c_one;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    logic w_burst_sel;
    logic w_aw_line_eq;
    logic w_aw_sub_eq;
    logic w_ar_line_eq;

    // A full-length AW burst widens the compare to the whole line.
    assign w_burst_sel  = r_burst[g] | (bus.awlen == 2'b11);
    assign w_aw_line_eq = (r_addr[g][c_addr_w-1:c_line_off] == bus.awaddr[CMP_HI:LINE_LO]);
    assign w_aw_sub_eq  = (r_addr[g] == bus.awaddr[CMP_HI:SUB_LO]);
    assign w_ar_line_eq = (r_addr[g][c_addr_w-1:c_line_off] == bus.araddr[CMP_HI:LINE_LO]);
    assign w_aw_hit[g]  = r_vld[g] & (w_burst_sel ? w_aw_line_eq : w_aw_sub_eq);
    assign w_ar_hit[g]  = r_vld[g] & w_ar_line_eq;
  end

  assign w_so_pend = |(r_vld & r_so);

  assign bus.ar_hit_wtable_addr = |w_ar_hit;
  assign bus.aw_hit_wtable_addr = |w_aw_hit;
  assign bus.ar_hit_wtable_so   = ~bus.arcache[1] & w_so_pend;
  assign bus.aw_hit_wtable_so   = ~bus.awcache[1] & w_so_pend;

  assign bus.wtable_create_rdy  = ~w_full;
  assign bus.wtable_create_idx  = w_free_idx;
  assign bus.wtable_vld         = r_vld;
  assign bus.wtable_cnt         = r_cnt;
  assign bus.wtable_full        = w_full;
  assign bus.wtable_empty       = (r_cnt == '0);
  assign bus.wtable_pop_err     = r_pop_err;

  logic w_unused;
  assign w_unused = ^{bus.wtable_create_addr[PADDR-1:CMP_HI+1],
                      bus.wtable_create_addr[SUB_LO-1:0],
                      bus.araddr[PADDR-1:CMP_HI+1], bus.araddr[LINE_LO-1:0],
                      bus.awaddr[PADDR-1:CMP_HI+1], bus.awaddr[SUB_LO-1:0],
                      bus.arcache[3:2], bus.arcache[0],
                      bus.awcache[3:2], bus.awcache[0]};

endmodule
`default_nettype wire

// File: tb/tb_aq_biu_wtable.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_aq_biu_wtable
// Purpose  : Directed plus randomized check of aq_biu_wtable against a table model
// Revision : 1.0 - initial release
// ============================================================================
module tb_aq_biu_wtable;
  localparam int DEPTH = 4;
  localparam int IDX_W = 2;
  localparam int PADDR = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aq_biu_wtable_if #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PADDR(PADDR)) bus ();

  aq_biu_wtable #(
    .DEPTH(DEPTH), .IDX_W(IDX_W), .PADDR(PADDR),
    .CMP_HI(13), .LINE_LO(6), .SUB_LO(4)
  ) dut (
    .forever_cpuclk(clk),
    .cpurst        (rst),
    .bus           (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: whole addresses per slot; compares done by xor/shift on full addresses.
  logic [3:0]  m_vld     = '0;
  logic [3:0]  m_so      = '0;
  logic [3:0]  m_burst   = '0;
  logic [39:0] m_addr [4];
  logic        m_pop_err = 1'b0;

  function automatic int m_free();
    for (int i = 0; i < 4; i++) if (!m_vld[i]) return i;
    return -1;
  endfunction

  function automatic logic same_line(input logic [39:0] a, input logic [39:0] b);
    return ((((a ^ b) >> 6) & 40'hFF) == 40'h0);
  endfunction

  function automatic logic same_sub(input logic [39:0] a, input logic [39:0] b);
    return ((((a ^ b) >> 4) & 40'h3FF) == 40'h0);
  endfunction

  function automatic logic m_ar_hit();
    for (int i = 0; i < 4; i++)
      if (m_vld[i] && same_line(m_addr[i], bus.araddr)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_aw_hit();
    for (int i = 0; i < 4; i++) begin
      if (m_vld[i]) begin
        if ((m_burst[i] || bus.awlen == 2'b11) ? same_line(m_addr[i], bus.awaddr)
                                                : same_sub(m_addr[i], bus.awaddr))
          return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld     <= '0;
      m_so      <= '0;
      m_burst   <= '0;
      m_pop_err <= 1'b0;
    end else begin
      if (bus.wtable_create_vld && m_free() >= 0) begin
        m_vld[2'(m_free())]   <= 1'b1;
        m_so[2'(m_free())]    <= bus.wtable_create_so;
        m_burst[2'(m_free())] <= bus.wtable_create_burst;
        m_addr[2'(m_free())]  <= bus.wtable_create_addr;
      end
      if (bus.wtable_pop_vld && m_vld[bus.wtable_pop_idx])
        m_vld[bus.wtable_pop_idx] <= 1'b0;
      m_pop_err <= bus.wtable_pop_vld && !m_vld[bus.wtable_pop_idx];
    end
  end

  always @(negedge clk) begin
    chk("cyc_vld",     64'(bus.wtable_vld),        64'(m_vld));
    chk("cyc_cnt",     64'(bus.wtable_cnt),        64'($countones(m_vld)));
    chk("cyc_full",    64'(bus.wtable_full),       64'(m_vld == 4'hF));
    chk("cyc_empty",   64'(bus.wtable_empty),      64'(m_vld == 4'h0));
    chk("cyc_rdy",     64'(bus.wtable_create_rdy), 64'(m_vld != 4'hF));
    chk("cyc_idx",     64'(bus.wtable_create_idx), 64'((m_free() < 0) ? 0 : m_free()));
    chk("cyc_pop_err", 64'(bus.wtable_pop_err),    64'(m_pop_err));
    chk("cyc_ar_hit",  64'(bus.ar_hit_wtable_addr), 64'(m_ar_hit()));
    chk("cyc_aw_hit",  64'(bus.aw_hit_wtable_addr), 64'(m_aw_hit()));
    chk("cyc_ar_so",   64'(bus.ar_hit_wtable_so),  64'(!bus.arcache[1] && (m_vld & m_so) != 0));
    chk("cyc_aw_so",   64'(bus.aw_hit_wtable_so),  64'(!bus.awcache[1] && (m_vld & m_so) != 0));
    chk("cnt_invariant", 64'(bus.wtable_cnt),      64'($countones(bus.wtable_vld)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_create(input logic [39:0] a, input logic so, input logic burst);
    bus.wtable_create_vld   = 1'b1;
    bus.wtable_create_addr  = a;
    bus.wtable_create_so    = so;
    bus.wtable_create_burst = burst;
    tick();
    bus.wtable_create_vld   = 1'b0;
  endtask

  task automatic do_pop(input logic [1:0] idx);
    bus.wtable_pop_vld = 1'b1;
    bus.wtable_pop_idx = idx;
    tick();
    bus.wtable_pop_vld = 1'b0;
  endtask

  function automatic logic [39:0] rnd_addr();
    logic [39:0] a;
    a = {8'($urandom), 32'($urandom)} & ~40'h3FF0;
    a = a | (40'($urandom_range(0, 3)) << 6) | (40'($urandom_range(0, 3)) << 4);
    return a;
  endfunction

  initial begin
    bus.wtable_create_vld   = 1'b0;
    bus.wtable_create_addr  = '0;
    bus.wtable_create_so    = 1'b0;
    bus.wtable_create_burst = 1'b0;
    bus.wtable_pop_vld      = 1'b0;
    bus.wtable_pop_idx      = '0;
    bus.araddr              = '0;
    bus.arcache             = 4'h2;
    bus.awaddr              = '0;
    bus.awcache             = 4'h2;
    bus.awlen               = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_vld",   64'(bus.wtable_vld),        64'h0);
    chk("rst_cnt",   64'(bus.wtable_cnt),        64'h0);
    chk("rst_empty", 64'(bus.wtable_empty),      64'h1);
    chk("rst_full",  64'(bus.wtable_full),       64'h0);
    chk("rst_rdy",   64'(bus.wtable_create_rdy), 64'h1);
    chk("rst_idx",   64'(bus.wtable_create_idx), 64'h0);
    chk("rst_perr",  64'(bus.wtable_pop_err),    64'h0);
    chk("rst_hits",  64'({bus.ar_hit_wtable_addr, bus.ar_hit_wtable_so,
                          bus.aw_hit_wtable_addr, bus.aw_hit_wtable_so}), 64'h0);

    for (int i = 0; i < 4; i++) begin
      chk("fill_idx", 64'(bus.wtable_create_idx), 64'(i));
      do_create(40'h1000 * 40'(i + 1), 1'b0, 1'b0);
      chk("fill_cnt", 64'(bus.wtable_cnt), 64'(i + 1));
    end
    chk("fill_full", 64'(bus.wtable_full),       64'h1);
    chk("fill_rdy",  64'(bus.wtable_create_rdy), 64'h0);
    do_create(40'h5000, 1'b0, 1'b0);
    chk("drop_cnt",  64'(bus.wtable_cnt), 64'h4);
    chk("drop_vld",  64'(bus.wtable_vld), 64'hF);

    do_pop(2'd0);
    chk("pop0_cnt", 64'(bus.wtable_cnt), 64'h3);
    chk("pop0_idx", 64'(bus.wtable_create_idx), 64'h0);
    do_create(40'h1040, 1'b1, 1'b0);
    bus.awaddr = 40'h1040; bus.awlen = 2'd0; #1;
    chk("aw_sub_hit",  64'(bus.aw_hit_wtable_addr), 64'h1);
    bus.awaddr = 40'h1050; #1;
    chk("aw_sub_miss", 64'(bus.aw_hit_wtable_addr), 64'h0);
    bus.awlen = 2'd3; #1;
    chk("aw_line_hit", 64'(bus.aw_hit_wtable_addr), 64'h1);
    bus.araddr = 40'h1070; #1;
    chk("ar_line_hit", 64'(bus.ar_hit_wtable_addr), 64'h1);
    bus.arcache = 4'b0000; #1;
    chk("ar_so_hit",   64'(bus.ar_hit_wtable_so), 64'h1);
    bus.arcache = 4'b0010; #1;
    chk("ar_so_buf",   64'(bus.ar_hit_wtable_so), 64'h0);
    bus.arcache = 4'b0000; bus.awcache = 4'b0000; #1;
    chk("aw_so_hit",   64'(bus.aw_hit_wtable_so), 64'h1);
    do_pop(2'd0);
    chk("so_after_pop",  64'(bus.ar_hit_wtable_so),   64'h0);
    chk("ar_after_pop",  64'(bus.ar_hit_wtable_addr), 64'h0);

    do_create(40'h1040, 1'b0, 1'b0);
    chk("refill_full", 64'(bus.wtable_full), 64'h1);
    bus.wtable_pop_vld = 1'b1; bus.wtable_pop_idx = 2'd1;
    do_create(40'h6000, 1'b0, 1'b0);
    bus.wtable_pop_vld = 1'b0;
    chk("full_pc_cnt", 64'(bus.wtable_cnt), 64'h3);
    chk("full_pc_vld", 64'(bus.wtable_vld), 64'hD);
    chk("full_pc_idx", 64'(bus.wtable_create_idx), 64'h1);
    do_create(40'h6000, 1'b0, 1'b0);
    chk("reuse_cnt",  64'(bus.wtable_cnt), 64'h4);
    chk("reuse_vld",  64'(bus.wtable_vld), 64'hF);

    do_pop(2'd2);
    do_pop(2'd2);
    chk("perr_pulse", 64'(bus.wtable_pop_err), 64'h1);
    chk("perr_vld",   64'(bus.wtable_vld),     64'hB);
    chk("perr_cnt",   64'(bus.wtable_cnt),     64'h3);
    tick();
    chk("perr_once",  64'(bus.wtable_pop_err), 64'h0);

    #3 rst = 1'b1;
    #1;
    chk("arst_vld",   64'(bus.wtable_vld),   64'h0);
    chk("arst_empty", 64'(bus.wtable_empty), 64'h1);
    chk("arst_cnt",   64'(bus.wtable_cnt),   64'h0);
    tick();
    rst = 1'b0;
    chk("arst_idx",   64'(bus.wtable_create_idx), 64'h0);
    do_create(40'h7000, 1'b0, 1'b1);
    chk("arst_first", 64'(bus.wtable_vld), 64'h1);

    repeat (3000) begin
      bus.wtable_create_vld   = ($urandom % 3) != 0;
      bus.wtable_create_addr  = rnd_addr();
      bus.wtable_create_so    = ($urandom % 4) == 0;
      bus.wtable_create_burst = ($urandom % 3) == 0;
      bus.wtable_pop_vld      = ($urandom % 2) == 0;
      bus.wtable_pop_idx      = 2'($urandom);
      bus.araddr              = rnd_addr();
      bus.arcache             = 4'($urandom);
      bus.awaddr              = rnd_addr();
      bus.awcache             = 4'($urandom);
      bus.awlen               = 2'($urandom);
      tick();
    end
    bus.wtable_create_vld = 1'b0;
    bus.wtable_pop_vld    = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/aq_biu_wtable.md
# aq_biu_wtable

Multi-entry write-outstanding table for the BIU. It is the parametrised successor of the single write-table entry. It tracks up to DEPTH in-flight AXI writes, each with a compare address, strongly-ordered (SO) flag and burst flag. It allocates entries on write issue and retires them by index when the B response returns. It flags read/write address and SO hazards so the AR/AW issue logic can stall, and exposes occupancy, full/empty and a pop-error indication.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, 2..16.
- IDX_W, 2: log2(DEPTH).
- PADDR, 40: physical address width.
- CMP_HI, 13: top address bit used in compares.
- LINE_LO, 6: low bit of the line-granular compare.
- SUB_LO, 4: low bit of the sub-line compare. Each entry stores addr[CMP_HI:SUB_LO].

Ports:
- forever_cpuclk  in  1  sole clock, ungated.
- cpurst  in  1  reset; asynchronous, active-high.
- wtable_create_vld  in  1  allocate request.
- wtable_create_addr  in  PADDR  write address.
- wtable_create_so  in  1  write is strongly ordered.
- wtable_create_burst  in  1  write is a burst; forces line-granular compare.
- wtable_create_rdy  out  1  a free entry exists.
- wtable_create_idx  out  IDX_W  index to be allocated (lowest free).
- wtable_pop_vld  in  1  retire request.
- wtable_pop_idx  in  IDX_W  entry to retire.
- araddr / arcache  in  PADDR / 4  read query.
- awaddr / awcache / awlen  in  PADDR / 4 / 2  write query.
- ar_hit_wtable_addr, ar_hit_wtable_so  out  1  read hazards.
- aw_hit_wtable_addr, aw_hit_wtable_so  out  1  write hazards.
- wtable_vld  out  DEPTH  per-entry valid vector.
- wtable_cnt  out  IDX_W+1  number of valid entries.
- wtable_full, wtable_empty  out  1  occupancy flags.
- wtable_pop_err  out  1  registered pulse: pop targeted an invalid entry.

## Operation
- Per entry, registered: vld, addr[CMP_HI:SUB_LO], so, burst. Reset clears everything. Only vld is required to reset; all fields are reset anyway for determinism.
- Allocate: a create fires when wtable_create_vld & wtable_create_rdy. The entry at wtable_create_idx gets vld=1 and captures addr/so/burst.
  - wtable_create_idx = lowest index with vld=0, from a priority encoder. It is 0 when full.
  - A create while not ready is dropped. No error is flagged; the requester must hold off.
- Retire: wtable_pop_vld with vld[pop_idx]=1 clears vld[pop_idx]. The entry's fields are left unchanged.
  - If vld[pop_idx]=0, state is unchanged and wtable_pop_err is 1 in the next cycle only.
- Per-entry AW hit:
  - burst_sel = entry.burst | (awlen==2'b11).
  - When burst_sel: compare addr[CMP_HI:LINE_LO].
  - Otherwise: compare addr[CMP_HI:SUB_LO].
  - The result is ANDed with vld.
- Per-entry AR hit: araddr[CMP_HI:LINE_LO] compare, ANDed with vld.
- Each address-hit output is the OR over all entries.
- ar_hit_wtable_so = !arcache[1] & OR(vld & so). aw_hit_wtable_so = !awcache[1] & OR(vld & so).
- wtable_cnt is a registered counter. Each cycle it changes by +create_fire −pop_fire, where pop_fire means a pop of a valid entry.
  - Invariant: cnt equals popcount(vld); the bench asserts it.
- wtable_full = (cnt==DEPTH). wtable_empty = (cnt==0). wtable_create_rdy = !wtable_full.

## Timing
- Reset values:
  - wtable_vld=0, wtable_cnt=0, wtable_empty=1.
  - wtable_full=0, wtable_create_rdy=1, wtable_create_idx=0.
  - wtable_pop_err=0, all hit outputs 0.
- Create latency: the entry is visible in vld, the hit outputs and cnt one cycle after the fire edge. There is no same-cycle bypass into the hit logic.
- Pop latency: the entry stops hitting one cycle after the pop edge.
- Hit outputs are combinational from registered state and the query inputs. Zero latency; the caller registers them if needed.
- Create and pop in the same cycle:
  - Both take effect and cnt is unchanged.
  - They cannot target the same entry, because create picks a free entry and pop acts only on a valid one.
- When full, a same-cycle pop does not unblock the create. rdy is computed from the current state; the freed slot is allocatable next cycle.
- Reset asserted mid-operation clears all entries immediately (asynchronous). The first create after reset release gets idx 0.
- The priority encoder wraps no state: after entries 0..3 are full and entry 1 is popped, the next create gets idx 1.

## Test plan
- Reset, then 4 creates with addresses 0x1000, 0x2000, 0x3000, 0x4000 -> idx 0,1,2,3; cnt 1..4; after the 4th, full=1 and rdy=0. A 5th create is dropped and cnt stays 4.
- Entry 0 holds 0x1040 with burst=0:
  - awaddr 0x1040 with awlen=0 -> aw_hit_wtable_addr=1.
  - awaddr 0x1050 with awlen=0 -> 0 (different 16B granule).
  - awaddr 0x1050 with awlen=3 -> 1 (same 64B line).
  - araddr 0x1070 -> ar_hit_wtable_addr=1.
- Entry with so=1:
  - arcache=4'b0000 -> ar_hit_wtable_so=1.
  - arcache=4'b0010 -> 0.
  - After popping that entry -> 0 in the next cycle.
- Full table, then pop idx 1 and create in the same cycle -> create dropped, cnt=3. The next-cycle create gets idx 1 and cnt=4.
- Pop idx 2 while vld[2]=0 -> wtable_pop_err=1 for exactly one cycle; vld and cnt unchanged.
- With 3 entries valid, assert cpurst mid-cycle -> vld=0, empty=1 and cnt=0 without waiting for a clock edge.
